// File: rtl/approx_error_monitor.sv
// approx_error_monitor: exhaustively sweeps a 2+2-bit approximate adder and reports error statistics.
// Ports: clk, rst (sync, active-high), start (begin sweep), dut_in[3:0] (adder operands b:a),
//        dut_out[2:0] (adder response), busy, done (1-cycle result pulse),
//        max_err[2:0], err_sum[6:0], viol_cnt[4:0], pass (max_err <= ET).
module approx_error_monitor #(
    parameter int ET     = 1,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_in,
    input  logic [2:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] max_err,
    output logic [6:0] err_sum,
    output logic [4:0] viol_cnt,
    output logic       pass
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    state_t     state, nxt;
    logic [3:0] vec;
    logic [3:0] cnt;
    logic [2:0] exact;
    logic [2:0] err;
    logic       settled;
    always_comb begin
        exact   = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
        err     = exact >= dut_out ? exact - dut_out : dut_out - exact;
        settled = 32'(cnt) == SETTLE - 1;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state == IDLE   ? (start ? DRIVE : IDLE) :
              state == DRIVE  ? (settled ? SAMPLE : DRIVE) :
              state == SAMPLE ? (vec == 4'd15 ? DONE : DRIVE) : IDLE;
    end
    always_comb begin
        busy   = state == DRIVE || state == SAMPLE;
        dut_in = busy ? vec : 4'd0;
    end
    // done is registered off the DONE state so it coincides with the updated pass flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec      <= '0;
            cnt      <= '0;
            max_err  <= '0;
            err_sum  <= '0;
            viol_cnt <= '0;
            pass     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= state == DONE;
            case (state)
                IDLE: if (start) begin
                    vec      <= '0;
                    cnt      <= '0;
                    max_err  <= '0;
                    err_sum  <= '0;
                    viol_cnt <= '0;
                end
                DRIVE: cnt <= settled ? 4'd0 : cnt + 4'd1;
                SAMPLE: begin
                    err_sum  <= err_sum + 7'(err);
                    max_err  <= err > max_err ? err : max_err;
                    viol_cnt <= 32'(err) > ET ? viol_cnt + 5'd1 : viol_cnt;
                    vec      <= vec == 4'd15 ? vec : vec + 4'd1;
                end
                default: pass <= 32'(max_err) <= ET;
            endcase
        end
    end
endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter ET, default 1: error threshold; a vector violates when |exact - approx| > ET.
REQ-002 Parameter SETTLE, default 1, legal range 1..15: cycles each vector is held on dut_in before sampling.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a full sweep.
REQ-006 dut_in  output  4  stimulus to the approximate adder under test; bit i drives port in<i>.
REQ-007 dut_out  input  3  response of the approximate adder under test; bit j is port out<j>.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes and results are valid.
REQ-010 max_err  output  3  largest absolute error seen during the last sweep.
REQ-011 err_sum  output  7  sum of absolute errors over all 16 vectors of the last sweep.
REQ-012 viol_cnt  output  5  number of vectors in the last sweep whose error exceeds ET.
REQ-013 pass  output  1  high when max_err <= ET; valid from done onward.

Function
REQ-014 The exact model SHALL be a = {dut_in[1], dut_in[0]}, b = {dut_in[3], dut_in[2]}, exact = a + b, 3 bits, no overflow possible (max 6).
REQ-015 Error per vector SHALL be |exact - dut_out|, computed unsigned on 3 bits, range 0..7.
REQ-016 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-017 IDLE: start=1 -> DRIVE; vector counter, max_err, err_sum and viol_cnt cleared on the same edge; dut_in = 0.
REQ-018 DRIVE: dut_in holds the current vector for exactly SETTLE cycles, then -> SAMPLE.
REQ-019 SAMPLE (one cycle): dut_out registered; error accumulated into err_sum; max_err updated if larger; viol_cnt incremented if error > ET.
REQ-020 SAMPLE with vector = 15 -> DONE; otherwise vector increments and -> DRIVE; vectors visited in ascending order 0..15, no wrap within a sweep.
REQ-021 DONE (one cycle): done = 1, pass updated; next state IDLE.
REQ-022 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-023 Latency: done SHALL assert 16*(SETTLE+1)+1 cycles after the edge that accepted start.
REQ-024 start while busy or in DONE SHALL be ignored, with no effect on the sweep or results.
REQ-025 Results (max_err, err_sum, viol_cnt, pass) SHALL hold stable from done until the next accepted start.
REQ-026 dut_in SHALL return to 0 in DONE and IDLE.
REQ-027 Accumulators SHALL NOT saturate; their widths cover the worst case (err_sum <= 112, viol_cnt <= 16).

Reset
REQ-028 rst=1 SHALL force IDLE, dut_in=0, busy=0, done=0, max_err=0, err_sum=0, viol_cnt=0, pass=0 on the next edge.
REQ-029 rst asserted mid-sweep SHALL abort the sweep with no done pulse; rst takes priority over start.

Verification
REQ-030 dut_out driven by the exact adder, SETTLE=1, start pulse -> done 33 cycles later; max_err=0, err_sum=0, viol_cnt=0, pass=1.
REQ-031 dut_out tied to 0 -> max_err=6, err_sum=48, viol_cnt=13, pass=0.
REQ-032 dut_out = exact+1 -> max_err=1, err_sum=16, viol_cnt=0, pass=1 (ET=1).
REQ-033 SETTLE=3, exact adder -> done 65 cycles after start; dut_in steps 0..15, each value held 4 cycles.
REQ-034 start re-pulsed at cycle 10 of a sweep -> ignored; exactly one done at the nominal cycle; results match a single clean sweep.
REQ-035 rst pulsed at cycle 12 of a sweep -> all outputs 0 next cycle, no done; a fresh start then completes normally.
